// File: rtl/spi_i2s_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_i2s_seq_ctrl
// Description : I2S master sequencer. It shadows the clock-generator config,
//               runs the WS/bit counters, and requests TX words ahead of time.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_i2s_seq_ctrl #(
    parameter int DRAIN_CYC = 4
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        cfg_i2se,
    input  logic        cfg_i2sms,
    input  logic        cfg_chlen,
    input  logic [13:0] cfg_i2sdiv,
    input  logic        cfg_odd,
    input  logic        cfg_ckpol,
    input  logic        cfg_mckoe,
    input  logic        start,
    input  logic        stop,
    input  logic        bit_tick,
    input  logic        ld_ack,
    output logic        bsy,
    output logic        i2se_o,
    output logic        chlen_o,
    output logic        odd_o,
    output logic        ckpol_o,
    output logic        mckoe_o,
    output logic [13:0] i2sdiv_o,
    output logic        ws,
    output logic [4:0]  bit_cnt,
    output logic        ld_req,
    output logic        frame_done,
    output logic        udr_err
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q;
    logic            bsy_q;
    logic            i2se_q;
    logic            chlen_q;
    logic            odd_q;
    logic            ckpol_q;
    logic            mckoe_q;
    logic [13:0]     i2sdiv_q;
    logic            ws_q;
    logic [4:0]      bit_cnt_q;
    logic            ld_req_q;
    logic            frame_done_q;
    logic            udr_err_q;
    logic            stop_pend_q;
    logic [DW-1:0]   drain_q;

    logic [4:0]      w_last;
    logic [4:0]      w_prelast;
    logic            w_stop_now;

    assign w_last     = chlen_q ? 5'd31 : 5'd15;
    assign w_prelast  = w_last - 5'd1;
    // A stop arriving on the wrap cycle itself must still be honoured there.
    assign w_stop_now = stop_pend_q | stop | ~cfg_i2se;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bsy_q        <= 1'b0;
            i2se_q       <= 1'b0;
            chlen_q      <= 1'b0;
            odd_q        <= 1'b0;
            ckpol_q      <= 1'b0;
            mckoe_q      <= 1'b0;
            i2sdiv_q     <= 14'd0;
            ws_q         <= 1'b0;
            bit_cnt_q    <= 5'd0;
            ld_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
            udr_err_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            drain_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    i2se_q      <= cfg_i2se;
                    chlen_q     <= cfg_chlen;
                    odd_q       <= cfg_odd;
                    ckpol_q     <= cfg_ckpol;
                    mckoe_q     <= cfg_mckoe;
                    i2sdiv_q    <= cfg_i2sdiv;
                    bsy_q       <= 1'b0;
                    ws_q        <= 1'b0;
                    bit_cnt_q   <= 5'd0;
                    stop_pend_q <= 1'b0;
                    if (start && cfg_i2se && cfg_i2sms) begin
                        state_q   <= S_ARM;
                        bsy_q     <= 1'b1;
                        ld_req_q  <= 1'b1;
                        udr_err_q <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (stop || !cfg_i2se) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (ld_ack) begin
                        state_q  <= S_RUN;
                        ld_req_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop || !cfg_i2se) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (ld_req_q && ld_ack) begin
                        ld_req_q <= 1'b0;
                    end
                    if (bit_tick) begin
                        if (bit_cnt_q == w_last) begin
                            bit_cnt_q <= 5'd0;
                            ws_q      <= ~ws_q;
                            if (ld_req_q && !ld_ack) begin
                                udr_err_q <= 1'b1;
                            end
                            if (ws_q) begin
                                frame_done_q <= 1'b1;
                                if (w_stop_now) begin
                                    state_q  <= S_DRAIN;
                                    ld_req_q <= 1'b0;
                                    drain_q  <= '0;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            // An ack coinciding with the request satisfies it outright.
                            if (bit_cnt_q == w_prelast && !ld_req_q && !ld_ack) begin
                                ld_req_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q     <= S_IDLE;
                        bsy_q       <= 1'b0;
                        ws_q        <= 1'b0;
                        stop_pend_q <= 1'b0;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bsy        = bsy_q;
    assign i2se_o     = i2se_q;
    assign chlen_o    = chlen_q;
    assign odd_o      = odd_q;
    assign ckpol_o    = ckpol_q;
    assign mckoe_o    = mckoe_q;
    assign i2sdiv_o   = i2sdiv_q;
    assign ws         = ws_q;
    assign bit_cnt    = bit_cnt_q;
    assign ld_req     = ld_req_q;
    assign frame_done = frame_done_q;
    assign udr_err    = udr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_i2s_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_i2s_seq_ctrl
// Description : Directed self-checking bench for spi_i2s_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_i2s_seq_ctrl;

    logic        pclk;
    logic        rst_n;
    logic        cfg_i2se;
    logic        cfg_i2sms;
    logic        cfg_chlen;
    logic [13:0] cfg_i2sdiv;
    logic        cfg_odd;
    logic        cfg_ckpol;
    logic        cfg_mckoe;
    logic        start;
    logic        stop;
    logic        bit_tick;
    logic        ld_ack;
    logic        bsy;
    logic        i2se_o;
    logic        chlen_o;
    logic        odd_o;
    logic        ckpol_o;
    logic        mckoe_o;
    logic [13:0] i2sdiv_o;
    logic        ws;
    logic [4:0]  bit_cnt;
    logic        ld_req;
    logic        frame_done;
    logic        udr_err;

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;

    spi_i2s_seq_ctrl #(.DRAIN_CYC(4)) u_dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cfg_i2se   (cfg_i2se),
        .cfg_i2sms  (cfg_i2sms),
        .cfg_chlen  (cfg_chlen),
        .cfg_i2sdiv (cfg_i2sdiv),
        .cfg_odd    (cfg_odd),
        .cfg_ckpol  (cfg_ckpol),
        .cfg_mckoe  (cfg_mckoe),
        .start      (start),
        .stop       (stop),
        .bit_tick   (bit_tick),
        .ld_ack     (ld_ack),
        .bsy        (bsy),
        .i2se_o     (i2se_o),
        .chlen_o    (chlen_o),
        .odd_o      (odd_o),
        .ckpol_o    (ckpol_o),
        .mckoe_o    (mckoe_o),
        .i2sdiv_o   (i2sdiv_o),
        .ws         (ws),
        .bit_cnt    (bit_cnt),
        .ld_req     (ld_req),
        .frame_done (frame_done),
        .udr_err    (udr_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick_cycle();
        bit_tick = 1'b1;
        cycle();
        bit_tick = 1'b0;
    endtask

    task automatic ack_cycle();
        ld_ack = ld_req;
        cycle();
        ld_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_i2se   = 1'b0;
        cfg_i2sms  = 1'b0;
        cfg_chlen  = 1'b0;
        cfg_i2sdiv = 14'd0;
        cfg_odd    = 1'b0;
        cfg_ckpol  = 1'b0;
        cfg_mckoe  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        bit_tick   = 1'b0;
        ld_ack     = 1'b0;
        #12;
        check("rst_bsy",    bsy,      0);
        check("rst_ws",     ws,       0);
        check("rst_bitcnt", bit_cnt,  0);
        check("rst_ldreq",  ld_req,   0);
        check("rst_udr",    udr_err,  0);
        check("rst_div",    i2sdiv_o, 0);
        cycle();
        rst_n = 1'b1;

        // Configure and start a 16-bit stream
        cfg_chlen  = 1'b0;
        cfg_i2sdiv = 14'd3;
        cfg_i2se   = 1'b1;
        cfg_i2sms  = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_bsy",   bsy,      1);
        check("start_div",   i2sdiv_o, 3);
        check("start_chlen", chlen_o,  0);
        check("start_ldreq", ld_req,   1);
        tick_cycle();
        check("arm_tick_ignored", bit_cnt, 0);
        check("arm_ldreq_hold",   ld_req,  1);
        ld_ack = 1'b1;
        cycle();
        ld_ack = 1'b0;
        check("arm_ack_ldreq", ld_req, 0);
        check("arm_ack_bsy",   bsy,    1);

        // Register write during RUN must not reach the shadow
        cfg_i2sdiv = 14'd9;
        for (int k = 1; k <= 64; k++) begin
            tick_cycle();
            check($sformatf("run16_bitcnt_%0d", k), bit_cnt, k % 16);
            check($sformatf("run16_ws_%0d", k), ws, (k / 16) % 2);
            check($sformatf("run16_ldreq_%0d", k), ld_req, (k % 16) == 15);
            check($sformatf("run16_fd_%0d", k), frame_done, (k % 32) == 0);
            if (frame_done) fd_count++;
            ack_cycle();
        end
        check("run16_fd_count", fd_count, 2);
        check("run16_udr",      udr_err,  0);
        check("run16_div_frozen", i2sdiv_o, 3);

        // Stop mid-frame; DRAIN after the right word, then bsy falls after 4 cycles
        for (int k = 1; k <= 31; k++) begin
            tick_cycle();
            if (k == 20) stop = 1'b1;
            ack_cycle();
            stop = 1'b0;
        end
        check("stop_before_wrap_bsy", bsy, 1);
        check("stop_before_wrap_ws",  ws,  1);
        tick_cycle();
        check("stop_wrap_fd",  frame_done, 1);
        check("stop_wrap_ws",  ws,         0);
        check("stop_wrap_bsy", bsy,        1);
        check("stop_wrap_ldreq", ld_req,   0);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check($sformatf("drain_bsy_%0d", i), bsy, (i < 4));
        end
        check("drain_ws", ws, 0);
        check("drain_div_still", i2sdiv_o, 3);
        cycle();
        check("idle_div_updated", i2sdiv_o, 9);

        // 32-bit stream with ack withheld across the left-word wrap
        cfg_chlen = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("c32_chlen", chlen_o, 1);
        check("c32_bsy",   bsy,     1);
        cycle();
        ld_ack = 1'b1;
        cycle();
        ld_ack = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick_cycle();
        end
        check("c32_bitcnt31", bit_cnt, 31);
        check("c32_ldreq31",  ld_req,  1);
        check("c32_udr31",    udr_err, 0);
        tick_cycle();
        check("c32_udr32",    udr_err, 1);
        check("c32_ws32",     ws,      1);
        check("c32_bitcnt32", bit_cnt, 0);
        check("c32_ldreq32",  ld_req,  1);
        cycle();
        cycle();
        cycle();
        check("c32_ldreq_held", ld_req, 1);
        ld_ack = 1'b1;
        cycle();
        ld_ack = 1'b0;
        check("c32_ldreq_acked", ld_req,  0);
        check("c32_udr_sticky",  udr_err, 1);

        // Asynchronous reset mid-RUN
        for (int k = 1; k <= 7; k++) begin
            tick_cycle();
        end
        check("prerst_bitcnt", bit_cnt, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bsy",    bsy,      0);
        check("arst_ws",     ws,       0);
        check("arst_bitcnt", bit_cnt,  0);
        check("arst_udr",    udr_err,  0);
        check("arst_ldreq",  ld_req,   0);
        check("arst_div",    i2sdiv_o, 0);
        check("arst_chlen",  chlen_o,  0);
        cycle();
        rst_n = 1'b1;

        // start with slave mode selected must be ignored
        cfg_i2sms = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("slave_bsy",   bsy,    0);
        check("slave_ldreq", ld_req, 0);
        cycle();
        cycle();
        check("slave_bsy_later", bsy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_i2s_seq_ctrl.md
Name: spi_i2s_seq_ctrl

Overview:
- Master-mode sequencer for the I2S clock generator and serializer in the SPI/I2S peripheral.
- Snapshots the register configuration into shadow outputs that the clock generator consumes, and drives bsy.
- Produces the word-select (WS) and bit/channel counters, and requests a data word from the TX path one bit ahead of each channel boundary.
- Stops cleanly only at a stereo frame boundary, then holds bsy through a short drain period.

Parameters:
- DRAIN_CYC, 4, pclk cycles bsy stays high after the last frame before returning to idle (minimum 1).

Ports:
- pclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_i2se  in  1  I2S enable register bit
- cfg_i2sms  in  1  master select; the sequencer only runs when this is 1
- cfg_chlen  in  1  channel length: 1 = 32-bit word, 0 = 16-bit word
- cfg_i2sdiv  in  14  prescaler value
- cfg_odd  in  1  odd-divide bit
- cfg_ckpol  in  1  clock idle polarity
- cfg_mckoe  in  1  master clock output enable
- start  in  1  one-cycle pulse: begin streaming
- stop  in  1  one-cycle pulse: request stop at the next frame end
- bit_tick  in  1  one pclk pulse per serial bit (active SCK edge, edge-detected by the caller)
- ld_ack  in  1  TX path accepted ld_req (may be the same cycle as ld_req or later)
- bsy  out  1  clock generator busy
- i2se_o, chlen_o, odd_o, ckpol_o, mckoe_o  out  1 each  shadowed configuration
- i2sdiv_o  out  14  shadowed prescaler
- ws  out  1  word select: 0 = left, 1 = right
- bit_cnt  out  5  bit index within the current word
- ld_req  out  1  level request for the next word, held until ld_ack
- frame_done  out  1  one-cycle pulse at the end of each right-channel word
- udr_err  out  1  sticky underrun flag

Behaviour:
- Reset (async): state=IDLE; bsy=0, ws=0, bit_cnt=0, ld_req=0, frame_done=0, udr_err=0, stop_pend=0.
  - Shadows: i2se_o=0, chlen_o=0, i2sdiv_o=0, odd_o=0, ckpol_o=0, mckoe_o=0.
- Word length WL = 32 if chlen_o else 16. bit_cnt wraps at WL-1.
- IDLE
  - Shadows track cfg_* every cycle; bsy=0.
  - On start with cfg_i2se=1 and cfg_i2sms=1 -> ARM next cycle. start is ignored otherwise.
  - ld_req=1 is set on entry to ARM.
- ARM
  - Shadows frozen; bsy=1; ws=0; bit_cnt=0; bit_tick ignored.
  - ld_ack -> RUN; ld_req drops the same edge.
- RUN
  - Shadows stay frozen, so register writes have no effect until IDLE.
  - On bit_tick with bit_cnt < WL-1: bit_cnt+1.
  - On bit_tick with bit_cnt == WL-2: set ld_req=1 if it is not already pending.
  - On bit_tick with bit_cnt == WL-1: bit_cnt=0 and ws toggles.
    - If ld_req is still pending (no ld_ack yet): udr_err=1. The request stays asserted and the word repeats.
    - If ws was 1 (right word ended): frame_done=1 for one cycle.
    - If ws was 1 and stop_pend=1: go to DRAIN and clear ld_req.
  - stop, or cfg_i2se sampled low, sets stop_pend.
  - start while not in IDLE is ignored.
- DRAIN
  - bsy=1 for exactly DRAIN_CYC cycles, then IDLE with bsy=0, ws=0, stop_pend=0.
  - bit_tick and ld_ack are ignored.
- Simultaneous events:
  - ld_ack in the same cycle as ld_req assertion: the request is satisfied and ld_req stays 0.
  - stop on the same cycle as the right-word wrap: honoured at that wrap (DRAIN next).
  - stop in ARM: sets stop_pend; one full frame is still sent.
- udr_err clears only on reset or on an accepted start.
- Reset mid-operation returns to IDLE immediately; no drain.

Test Plan:
- Reset, then cfg chlen=0, i2sdiv=3, i2se=1, i2sms=1, start, ld_ack after 2 cycles -> bsy=1 one cycle after start; RUN entered; shadows = 0/3.
- 16-bit run with 64 bit_ticks, ld_ack always 1 cycle after ld_req -> ws toggles after ticks 16/32/48/64; 2 frame_done pulses; ld_req rises on ticks 15/31/47/63; udr_err=0.
- chlen=1 run with ld_ack withheld past tick 32 -> udr_err=1 at tick 32 and stays 1; ws still toggles; ld_req stays high until ack.
- stop pulse at tick 20 of a 16-bit stream -> DRAIN after tick 32 (right word end); bsy falls exactly 4 cycles later; ws=0.
- Write cfg_i2sdiv=9 while in RUN -> i2sdiv_o stays 3 until IDLE, then becomes 9.
- Assert rst_n=0 mid-RUN at bit_cnt=7 -> all outputs at reset values asynchronously; start with i2sms=0 afterwards -> stays IDLE.
